// File: rtl/vga_scandoubler_if.sv
// Video bus between the ULA pixel source and the scan doubler.
// The master drives ULA pixels and syncs; the slave returns the output video.
interface vga_scandoubler_if;
  logic pix_ce;
  logic scandbl_en;
  logic r_in;
  logic g_in;
  logic b_in;
  logic i_in;
  logic hsync_n_in;
  logic vsync_n_in;
  logic r;
  logic g;
  logic b;
  logic i;
  logic hsync_n;
  logic vsync_n;

  modport master (
    output pix_ce, scandbl_en, r_in, g_in, b_in, i_in, hsync_n_in, vsync_n_in,
    input  r, g, b, i, hsync_n, vsync_n
  );

  modport slave (
    input  pix_ce, scandbl_en, r_in, g_in, b_in, i_in, hsync_n_in, vsync_n_in,
    output r, g, b, i, hsync_n, vsync_n
  );
endinterface

// File: rtl/vga_scandoubler.sv
// Line-doubling scan converter for the 48K ULA: 15.6 kHz RGBI in, 31.2 kHz VGA out,
// using a two-bank line buffer, with a native-rate composite-sync bypass.
module vga_scandoubler #(
  parameter int ADDR_W   = 9,
  parameter int MAX_LINE = 448,
  parameter int MIN_LINE = 64,
  parameter int HS_WIDTH = 54
) (
  input logic clk14,
  input logic reset_n,
  vga_scandoubler_if.slave vid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W + 1)'(MAX_LINE);
  localparam logic [ADDR_W:0]   MIN_LEN = (ADDR_W + 1)'(MIN_LINE);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] HS_LEN  = ADDR_W'(HS_WIDTH);
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  logic              hs_prev;
  logic              hs_fall;
  logic              line_accept;
  logic              wr_en;
  logic [3:0]        wr_data;
  logic [ADDR_W-1:0] wcnt;
  logic              wbank;
  logic [ADDR_W:0]   line_len;
  logic [ADDR_W-1:0] rcnt;
  logic              rcnt_wrap;
  logic [ADDR_W-1:0] rcnt_d;
  logic [3:0]        rd_data;
  logic              in_blank;
  logic [3:0]        vga_col;
  logic              vsync_d;
  logic [3:0]        col_q;
  logic              hsync_q;
  logic              vsync_q;

  logic [3:0] line_buf [0:2*DEPTH-1];

  // A falling hsync only starts a new line once enough pixels have been seen;
  // shorter intervals are sync glitches and leave all line state untouched.
  assign hs_fall     = hs_prev & ~vid.hsync_n_in;
  assign line_accept = hs_fall && ({1'b0, wcnt} >= MIN_LEN);
  assign wr_en       = vid.pix_ce && !line_accept && ({1'b0, wcnt} < MAX_LEN);
  assign wr_data     = {vid.i_in, vid.g_in, vid.r_in, vid.b_in};
  assign rcnt_wrap   = ({1'b0, rcnt} == (line_len - LEN_ONE));

  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= 1'b1;
      wcnt     <= '0;
      wbank    <= 1'b0;
      line_len <= MAX_LEN;
    end else begin
      hs_prev <= vid.hsync_n_in;
      if (line_accept) begin
        line_len <= {1'b0, wcnt};
        wcnt     <= '0;
        wbank    <= ~wbank;
      end else if (wr_en) begin
        wcnt <= wcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk14) begin
    if (wr_en) begin
      line_buf[{wbank, wcnt}] <= wr_data;
    end
  end

  // The read side replays the idle bank twice per input line at clk14 rate.
  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      rcnt    <= '0;
      rcnt_d  <= '0;
      rd_data <= 4'h0;
      vsync_d <= 1'b1;
    end else begin
      if (line_accept || rcnt_wrap) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + CNT_ONE;
      end
      rd_data <= line_buf[{~wbank, rcnt}];
      rcnt_d  <= rcnt;
      vsync_d <= vid.vsync_n_in;
    end
  end

  assign in_blank = (rcnt_d < HS_LEN);
  assign vga_col  = in_blank ? 4'h0 : rd_data;

  // Output mux follows scandbl_en cycle by cycle; both paths keep running.
  always_ff @(posedge clk14 or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= 4'h0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (vid.scandbl_en) begin
      col_q   <= vga_col;
      hsync_q <= ~in_blank;
      vsync_q <= vsync_d;
    end else begin
      if (vid.pix_ce) begin
        col_q <= wr_data;
      end
      hsync_q <= vid.hsync_n_in & vid.vsync_n_in;
      vsync_q <= 1'b1;
    end
  end

  assign vid.i       = col_q[3];
  assign vid.g       = col_q[2];
  assign vid.r       = col_q[1];
  assign vid.b       = col_q[0];
  assign vid.hsync_n = hsync_q;
  assign vid.vsync_n = vsync_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// Self-checking bench for vga_scandoubler: a line-level model predicts every output
// cycle, and literal checks pin hsync width/period, sample colour and reset values.
module tb_vga_scandoubler;

  logic clk14 = 1'b0;
  logic reset_n = 1'b1;

  vga_scandoubler_if vid ();

  vga_scandoubler dut (
    .clk14  (clk14),
    .reset_n(reset_n),
    .vid    (vid)
  );

  always #5 clk14 = ~clk14;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Each accepted input line: the cycle its edge was sampled, its length and pixels.
  typedef struct {
    int         start;
    int         len;
    int         count;
    logic [3:0] pix [448];
  } line_rec_t;

  line_rec_t  recs[$];
  logic [3:0] cur_pix [448];
  int         wc = 0;
  logic       prev_hs = 1'b1;
  logic       vs_prev = 1'b1;
  logic [3:0] byp_col = 4'h0;
  bit         byp_known = 1'b1;
  int         valid_from = 32'h7fffffff;
  logic       exp_hs = 1'b1;
  logic       exp_vs = 1'b1;
  logic [3:0] exp_col = 4'h0;
  bit         exp_col_known = 1'b0;
  bit         exp_valid = 1'b0;

  // Model: output after edge m shows phase (m-2-E) mod len of the line accepted at E.
  always @(posedge clk14) begin : model
    logic       hs, vs, pce, en, fall;
    logic [3:0] col;
    int         sel, phase;
    line_rec_t  rec;
    cyc++;
    if (!reset_n) begin
      recs.delete();
      rec.start = cyc;
      rec.len   = 448;
      rec.count = 0;
      recs.push_back(rec);
      wc         = 0;
      prev_hs    = 1'b1;
      vs_prev    = 1'b1;
      byp_col    = 4'h0;
      byp_known  = 1'b1;
      valid_from = cyc + 2;
    end else begin
      hs   = vid.hsync_n_in;
      vs   = vid.vsync_n_in;
      pce  = vid.pix_ce;
      en   = vid.scandbl_en;
      col  = {vid.i_in, vid.g_in, vid.r_in, vid.b_in};
      fall = prev_hs && !hs;
      prev_hs = hs;
      if (fall && wc >= 64) begin
        rec.start = cyc;
        rec.len   = wc;
        rec.count = wc;
        rec.pix   = cur_pix;
        recs.push_back(rec);
        if (recs.size() > 3) void'(recs.pop_front());
        wc = 0;
      end else if (pce && wc < 448) begin
        cur_pix[wc] = col;
        wc++;
      end
      if (en) begin
        sel = 0;
        for (int k = recs.size() - 1; k >= 0; k--) begin
          if (recs[k].start <= cyc - 2) begin
            sel = k;
            break;
          end
        end
        phase  = (cyc - 2 - recs[sel].start) % recs[sel].len;
        exp_hs = (phase >= 54);
        if (phase < 54) begin
          exp_col       = 4'h0;
          exp_col_known = 1'b1;
        end else if (phase < recs[sel].count) begin
          exp_col       = recs[sel].pix[phase];
          exp_col_known = 1'b1;
        end else begin
          exp_col_known = 1'b0;
        end
        exp_vs    = vs_prev;
        byp_known = 1'b0;
      end else begin
        exp_hs = hs & vs;
        exp_vs = 1'b1;
        if (pce) begin
          byp_col   = col;
          byp_known = 1'b1;
        end
        exp_col       = byp_col;
        exp_col_known = byp_known;
      end
      vs_prev = vs;
    end
    exp_valid = reset_n && (cyc >= valid_from);
  end

  // Every cycle the outputs are meaningful, compare against the model.
  always @(negedge clk14) begin
    if (!reset_n) begin
      checkOutput("reset_colour", {vid.i, vid.g, vid.r, vid.b}, 4'h0);
      checkOutput("reset_hsync", vid.hsync_n, 1'b1);
      checkOutput("reset_vsync", vid.vsync_n, 1'b1);
    end else if (exp_valid) begin
      checkOutput("hsync_n", vid.hsync_n, exp_hs);
      checkOutput("vsync_n", vid.vsync_n, exp_vs);
      if (exp_col_known) checkOutput("colour", {vid.i, vid.g, vid.r, vid.b}, exp_col);
    end
  end

  // Measures output hsync pulses and grabs the colour 100 cycles into each line.
  logic       prev_out_hs = 1'b1;
  bit         fall_seen = 1'b0;
  int         out_phase = 0;
  int         last_fall = 0;
  int         last_period = 0;
  int         period_stamp = 0;
  int         last_width = 0;
  int         width_stamp = 0;
  logic [3:0] col100 = 4'h0;
  int         col100_stamp = 0;

  always @(negedge clk14) begin
    if (!reset_n) begin
      prev_out_hs = 1'b1;
      fall_seen   = 1'b0;
      out_phase   = 0;
    end else begin
      if (prev_out_hs && !vid.hsync_n) begin
        if (fall_seen) begin
          last_period  = cyc - last_fall;
          period_stamp = cyc;
        end
        last_fall = cyc;
        fall_seen = 1'b1;
        out_phase = 0;
      end else begin
        out_phase++;
      end
      if (!prev_out_hs && vid.hsync_n && fall_seen) begin
        last_width  = cyc - last_fall;
        width_stamp = cyc;
      end
      if (fall_seen && out_phase == 100) begin
        col100       = {vid.i, vid.g, vid.r, vid.b};
        col100_stamp = cyc;
      end
      prev_out_hs = vid.hsync_n;
    end
  end

  // One input line: hsync low for 8 clocks, pixels on odd clocks with colour = index.
  task automatic applyStimulus(input int npix, input int clocks, input int glitch_at,
                               input bit vs_pulse);
    int k;
    k = 0;
    for (int c = 0; c < clocks; c++) begin
      @(negedge clk14);
      vid.hsync_n_in = !((c < 8) || (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 4));
      vid.vsync_n_in = !(vs_pulse && c >= 200 && c < 204);
      if ((c % 2 == 1) && (k < npix)) begin
        vid.pix_ce = 1'b1;
        {vid.i_in, vid.g_in, vid.r_in, vid.b_in} = 4'(k);
        k++;
      end else begin
        vid.pix_ce = 1'b0;
        {vid.i_in, vid.g_in, vid.r_in, vid.b_in} = 4'hF;
      end
    end
  endtask

  initial begin
    int t0;
    vid.pix_ce     = 1'b0;
    vid.scandbl_en = 1'b1;
    vid.r_in       = 1'b0;
    vid.g_in       = 1'b0;
    vid.b_in       = 1'b0;
    vid.i_in       = 1'b0;
    vid.hsync_n_in = 1'b1;
    vid.vsync_n_in = 1'b1;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk14);
    checkOutput("por_colour", {vid.i, vid.g, vid.r, vid.b}, 4'h0);
    checkOutput("por_hsync", vid.hsync_n, 1'b1);
    checkOutput("por_vsync", vid.vsync_n, 1'b1);
    #2 reset_n = 1'b1;

    // Full 448-pixel lines doubled to 448-clock VGA lines
    for (int n = 0; n < 3; n++) applyStimulus(448, 896, -1, n == 1);
    t0 = cyc;
    applyStimulus(448, 896, -1, 1'b0);
    checkOutput("t448_width", (width_stamp > t0) ? last_width : -1, 54);
    checkOutput("t448_period", (period_stamp > t0) ? last_period : -1, 448);
    checkOutput("t448_col100", (col100_stamp > t0) ? {28'h0, col100} : -1, 4'h4);

    // Shorter 416-pixel lines
    for (int n = 0; n < 2; n++) applyStimulus(416, 832, -1, 1'b0);
    t0 = cyc;
    applyStimulus(416, 832, -1, 1'b0);
    checkOutput("t416_period", (period_stamp > t0) ? last_period : -1, 416);
    checkOutput("t416_width", (width_stamp > t0) ? last_width : -1, 54);

    // Short hsync glitch 20 pixels into a line is ignored
    t0 = cyc;
    applyStimulus(416, 832, 41, 1'b0);
    checkOutput("glitch_period", (period_stamp > t0) ? last_period : -1, 416);
    applyStimulus(416, 832, -1, 1'b0);

    // 500 pixels per line saturate at 448
    applyStimulus(500, 1000, -1, 1'b0);
    t0 = cyc;
    applyStimulus(500, 1000, -1, 1'b0);
    checkOutput("sat_period", (period_stamp > t0) ? last_period : -1, 448);

    // Bypass mode: composite sync, vsync held high
    vid.scandbl_en = 1'b0;
    applyStimulus(448, 896, -1, 1'b1);
    applyStimulus(448, 896, -1, 1'b0);
    @(negedge clk14);
    vid.pix_ce     = 1'b0;
    vid.vsync_n_in = 1'b0;
    #1 checkOutput("byp_hs_registered", vid.hsync_n, 1'b1);
    @(negedge clk14);
    checkOutput("byp_hs_and_vs", vid.hsync_n, 1'b0);
    checkOutput("byp_vsync_high", vid.vsync_n, 1'b1);
    vid.vsync_n_in = 1'b1;
    @(negedge clk14);
    checkOutput("byp_hs_release", vid.hsync_n, 1'b1);

    // Back to doubling in the middle of a line
    fork
      applyStimulus(448, 896, -1, 1'b0);
      begin
        repeat (300) @(negedge clk14);
        vid.scandbl_en = 1'b1;
      end
    join
    applyStimulus(448, 896, -1, 1'b0);

    // Asynchronous reset in the middle of a line
    fork
      applyStimulus(448, 896, -1, 1'b0);
      begin
        repeat (500) @(negedge clk14);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_colour", {vid.i, vid.g, vid.r, vid.b}, 4'h0);
        checkOutput("mid_rst_hsync", vid.hsync_n, 1'b1);
        checkOutput("mid_rst_vsync", vid.vsync_n, 1'b1);
        repeat (3) @(negedge clk14);
        #2 reset_n = 1'b1;
      end
    join
    applyStimulus(448, 896, -1, 1'b0);
    applyStimulus(448, 896, -1, 1'b1);
    t0 = cyc;
    applyStimulus(448, 896, -1, 1'b0);
    checkOutput("post_rst_period", (period_stamp > t0) ? last_period : -1, 448);
    checkOutput("post_rst_width", (width_stamp > t0) ? last_width : -1, 54);
    checkOutput("post_rst_col100", (col100_stamp > t0) ? {28'h0, col100} : -1, 4'h4);

    repeat (4) @(negedge clk14);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_scandoubler.md
Name: vga_scandoubler

Overview:
- Sits directly downstream of the 48K ULA video output. Converts the 15.6 kHz RGBI stream to a 31.2 kHz VGA-rate stream by line doubling.
- Each input line is written into one half of a two-line buffer at pixel rate. The other half is read out twice at double rate, with a regenerated VGA hsync.
- A bypass mode passes the native 15 kHz signal through with composite sync.

Parameters:
- ADDR_W, 9, line buffer address width (entries per bank = 2**ADDR_W).
- MAX_LINE, 448, maximum stored pixels per input line; writes beyond are dropped.
- MIN_LINE, 64, minimum valid measured line length; shorter lines are treated as sync glitches.
- HS_WIDTH, 54, VGA hsync width in clk14 cycles (about 3.8 us).

Ports:
- clk14  in  1  14 MHz master clock.
- reset_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  one-clk14 strobe per ULA pixel (7 MHz rate).
- scandbl_en  in  1  1 = VGA doubled output, 0 = 15 kHz bypass.
- r_in, g_in, b_in, i_in  in  1 each  ULA pixel colour, valid when pix_ce = 1.
- hsync_n_in  in  1  ULA horizontal sync, active low.
- vsync_n_in  in  1  ULA vertical sync, active low.
- r, g, b, i  out  1 each  output colour, registered.
- hsync_n  out  1  output hsync (VGA mode) or csync (bypass), registered.
- vsync_n  out  1  output vsync, registered.

Behaviour:
- Single clock domain is clk14; all flops clear on reset_n = 0.

Reset values:
- r, g, b, i = 0; hsync_n = 1; vsync_n = 1.
- wcnt = 0, rcnt = 0, wbank = 0, line_len = 448, hs_prev = 1.

Input line edge:
- hs_fall = hs_prev & ~hsync_n_in, where hs_prev is the registered hsync_n_in sampled every clk14.
- On hs_fall with wcnt >= MIN_LINE:
  - line_len <= wcnt;
  - wcnt <= 0;
  - wbank <= ~wbank;
  - rcnt <= 0.
- On hs_fall with wcnt < MIN_LINE: the edge is ignored (glitch); counters keep running.

Write side:
- On pix_ce with wcnt < MAX_LINE: store {i_in, g_in, r_in, b_in} at buffer[wbank][wcnt]; wcnt <= wcnt + 1.
- On pix_ce with wcnt = MAX_LINE: no write, and wcnt holds (saturates).
- If pix_ce and an accepted hs_fall coincide, the hs_fall wins: that pixel is not stored and wcnt becomes 0.

Read side, VGA mode:
- Every clk14, rcnt increments; when rcnt = line_len - 1 it wraps to 0. This gives exactly two output lines per input line.
- Read address is buffer[~wbank][rcnt]. RAM output is registered, so read latency is 1 clk14.
- Colour outputs take the RAM data when rcnt (delayed 1) >= HS_WIDTH, else 0000 (blank during hsync).
- hsync_n = 0 while rcnt (delayed 1) < HS_WIDTH.
- vsync_n = vsync_n_in delayed 2 clk14.
- Read-during-write to the same bank never occurs, because banks are always opposite.

Bypass mode (scandbl_en = 0):
- r, g, b, i = inputs registered on pix_ce.
- hsync_n = hsync_n_in & vsync_n_in (registered).
- vsync_n = 1.
- Buffer writes and counters keep running, so switching modes is glitch-free at the next line boundary.

scandbl_en changes mid-line:
- Takes effect on the next clk14 for the output mux only.
- No counter is reset.

Reset mid-line:
- All state clears.
- The first accepted hs_fall re-aligns the pipeline.
- Output content before that edge is undefined colour but correctly blanked or synced per the counters.

Widths:
- wcnt and rcnt are ADDR_W bits; line_len is ADDR_W+1 bits so it can hold MAX_LINE.
- All compares are unsigned.

Test Plan:
- Reset, then 448 pix_ce pulses with colour = wcnt[3:0] and hs_fall every 896 clk14 -> after the second line, every line gives two hsync_n lows of 54 clk14, 448 clk14 apart, and output colour at rcnt = 100 equals 4'h4.
- Line length 416 pixels -> line_len = 416, rcnt wraps at 415, and hsync period = 416 clk14.
- Glitch low on hsync_n_in 20 pixels after a valid edge -> ignored: wbank does not toggle and line_len is unchanged.
- 500 pix_ce pulses before hs_fall -> wcnt saturates at 448, line_len = 448, no RAM address overflow.
- scandbl_en = 0 -> hsync_n follows hsync_n_in AND vsync_n_in with 1 clk14 delay, and vsync_n stays 1.
- Assert reset_n low mid-line -> all outputs take reset values immediately (asynchronous); after release, correct doubling resumes from the second valid hs_fall.
